// File: rtl/hit_capture_pkg.sv
// Shared widths, octave limits and debounce default for the play-mode hit front end.
// Also provides the lowest-set-bit key encoder used for notes and lengths.
package hit_capture_pkg;

    localparam int NOTE_KEY_BITS   = 32'sd7;
    localparam int LENGTH_KEY_BITS = 32'sd4;
    localparam int NOTE_BITS       = 32'sd3;
    localparam int LENGTH_BITS     = 32'sd3;
    localparam int OCTAVE_BITS     = 32'sd2;
    localparam int CLOCK_BITS      = 32'sd32;
    localparam int DEBOUNCE_BITS   = 32'sd20;

    localparam logic [DEBOUNCE_BITS-1:0] DEBOUNCE_CYCLES_DEF = 20'd1_000_000;

    localparam logic [OCTAVE_BITS-1:0] OCT_MIN   = 2'd0;
    localparam logic [OCTAVE_BITS-1:0] OCT_MAX   = 2'd2;
    localparam logic [OCTAVE_BITS-1:0] OCT_RESET = 2'd1;

    localparam logic [NOTE_BITS-1:0] REST_NOTE = 3'd0;

    // Debouncer slots: hit, octave up, octave down, then note keys, then length keys.
    localparam int IDX_HIT    = 32'sd0;
    localparam int IDX_UP     = 32'sd1;
    localparam int IDX_DOWN   = 32'sd2;
    localparam int IDX_NOTE   = 32'sd3;
    localparam int IDX_LENGTH = IDX_NOTE + NOTE_KEY_BITS;
    localparam int NUM_INPUTS = IDX_LENGTH + LENGTH_KEY_BITS;

    function automatic logic [NOTE_BITS-1:0] encode_lowest(input logic [NOTE_KEY_BITS-1:0] keys);
        logic [NOTE_BITS-1:0] code;
        code = REST_NOTE;
        for (int i = NOTE_KEY_BITS - 32'sd1; i >= 32'sd0; i--) begin
            if (keys[i]) begin
                code = NOTE_BITS'(i + 32'sd1);
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/debounce_edge.sv
// Single-bit debouncer: accepts a new level after CYCLES stable differing samples
// and emits a one-cycle pulse on each accepted rising edge.
module debounce_edge
    import hit_capture_pkg::*;
#(
    parameter logic [DEBOUNCE_BITS-1:0] CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic level,
    output logic rise_pulse
);

    logic                     sample_r;
    logic                     level_r;
    logic                     rise_r;
    logic [DEBOUNCE_BITS-1:0] cnt_r;

    // Sample the raw input, count stable differing cycles, accept and flag rising edges.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sample_r <= 1'b0;
            level_r  <= 1'b0;
            rise_r   <= 1'b0;
            cnt_r    <= '0;
        end else begin
            sample_r <= sig;
            rise_r   <= 1'b0;
            if (sample_r == level_r) begin
                cnt_r <= '0;
            end else if (cnt_r == CYCLES - 20'd1) begin
                level_r <= sample_r;
                rise_r  <= sample_r;
                cnt_r   <= '0;
            end else begin
                cnt_r <= cnt_r + 20'd1;
            end
        end
    end

    assign level      = level_r;
    assign rise_pulse = rise_r;

endmodule

// File: rtl/hit_capture.sv
// Play-mode front end: debounces player inputs, tracks the octave and emits one
// timestamped hit record per accepted hit press over a valid/ready handshake.
module hit_capture
    import hit_capture_pkg::*;
#(
    parameter logic [DEBOUNCE_BITS-1:0] DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       en_hit,
    input  logic                       oct_up,
    input  logic                       oct_down,
    input  logic [NOTE_KEY_BITS-1:0]   note_key,
    input  logic [LENGTH_KEY_BITS-1:0] length_key,
    input  logic [CLOCK_BITS-1:0]      system_clock,
    input  logic                       hit_ready,
    output logic                       hit_valid,
    output logic [CLOCK_BITS-1:0]      hit_clock,
    output logic [OCTAVE_BITS-1:0]     hit_octave,
    output logic [NOTE_BITS-1:0]       hit_note,
    output logic [LENGTH_BITS-1:0]     hit_length,
    output logic [OCTAVE_BITS-1:0]     octave,
    output logic                       hit_dropped
);

    logic [NUM_INPUTS-1:0]    raw_s;
    logic [IDX_DOWN:IDX_HIT]  rise_s;
    logic [NUM_INPUTS-1:IDX_NOTE] level_s;

    logic [OCTAVE_BITS-1:0]   octave_next_s;
    logic [NOTE_BITS-1:0]     note_code_s;
    logic [LENGTH_BITS-1:0]   length_code_s;

    logic                     hit_valid_r;
    logic [CLOCK_BITS-1:0]    hit_clock_r;
    logic [OCTAVE_BITS-1:0]   hit_octave_r;
    logic [NOTE_BITS-1:0]     hit_note_r;
    logic [LENGTH_BITS-1:0]   hit_length_r;
    logic [OCTAVE_BITS-1:0]   octave_r;
    logic                     hit_dropped_r;

    assign raw_s = {length_key, note_key, oct_down, oct_up, en_hit};

    // Buttons only need their edge pulse; keys only need their held level.
    for (genvar g = 32'sd0; g < NUM_INPUTS; g++) begin : g_deb
        if (g <= IDX_DOWN) begin : g_ctrl
            logic unused_level;
            debounce_edge #(.CYCLES(DEBOUNCE_CYCLES)) u_deb (
                .clk        (clk),
                .rst_n      (rst_n),
                .sig        (raw_s[g]),
                .level      (unused_level),
                .rise_pulse (rise_s[g])
            );
        end else begin : g_key
            logic unused_rise;
            debounce_edge #(.CYCLES(DEBOUNCE_CYCLES)) u_deb (
                .clk        (clk),
                .rst_n      (rst_n),
                .sig        (raw_s[g]),
                .level      (level_s[g]),
                .rise_pulse (unused_rise)
            );
        end
    end

    assign note_code_s   = encode_lowest(level_s[IDX_LENGTH-1:IDX_NOTE]);
    assign length_code_s = LENGTH_BITS'(encode_lowest({3'b000, level_s[NUM_INPUTS-1:IDX_LENGTH]}));

    // Saturating octave step; simultaneous up and down cancel.
    always_comb begin
        octave_next_s = octave_r;
        case ({rise_s[IDX_UP], rise_s[IDX_DOWN]})
            2'b10: begin
                if (octave_r < OCT_MAX) octave_next_s = octave_r + 2'd1;
                else                    octave_next_s = octave_r;
            end
            2'b01: begin
                if (octave_r > OCT_MIN) octave_next_s = octave_r - 2'd1;
                else                    octave_next_s = octave_r;
            end
            default: octave_next_s = octave_r;
        endcase
    end

    // Octave tracking plus the one-deep record register and its handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_valid_r   <= 1'b0;
            hit_clock_r   <= '0;
            hit_octave_r  <= '0;
            hit_note_r    <= '0;
            hit_length_r  <= '0;
            octave_r      <= OCT_RESET;
            hit_dropped_r <= 1'b0;
        end else if (!en) begin
            hit_valid_r   <= 1'b0;
            hit_dropped_r <= 1'b0;
            octave_r      <= OCT_RESET;
        end else begin
            octave_r <= octave_next_s;
            if (rise_s[IDX_HIT]) begin
                if (!hit_valid_r || hit_ready) begin
                    // Record carries the octave in force before this cycle's step.
                    hit_valid_r  <= 1'b1;
                    hit_clock_r  <= system_clock;
                    hit_octave_r <= octave_r;
                    hit_note_r   <= note_code_s;
                    hit_length_r <= length_code_s;
                end else begin
                    hit_dropped_r <= 1'b1;
                end
            end else if (hit_valid_r && hit_ready) begin
                hit_valid_r <= 1'b0;
            end else begin
                hit_valid_r <= hit_valid_r;
            end
        end
    end

    assign hit_valid   = hit_valid_r;
    assign hit_clock   = hit_clock_r;
    assign hit_octave  = hit_octave_r;
    assign hit_note    = hit_note_r;
    assign hit_length  = hit_length_r;
    assign octave      = octave_r;
    assign hit_dropped = hit_dropped_r;

endmodule

// File: tb/tb_hit_capture.sv
// Directed bench for hit_capture with a 4-cycle debounce: stimulus queues the
// expected records, a negedge monitor matches each newly presented record.
module tb_hit_capture;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        en_hit;
    logic        oct_up;
    logic        oct_down;
    logic [6:0]  note_key;
    logic [3:0]  length_key;
    logic [31:0] system_clock;
    logic        hit_ready;
    logic        hit_valid;
    logic [31:0] hit_clock;
    logic [1:0]  hit_octave;
    logic [2:0]  hit_note;
    logic [2:0]  hit_length;
    logic [1:0]  octave;
    logic        hit_dropped;

    typedef struct packed {
        logic [31:0] clk_v;
        logic [1:0]  oct;
        logic [2:0]  note;
        logic [2:0]  len;
    } rec_t;

    rec_t exp_q[$];
    rec_t last_exp;
    rec_t got;
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   n_records = 0;
    logic prev_valid = 1'b0;
    logic prev_xfer  = 1'b0;

    hit_capture #(.DEBOUNCE_CYCLES(20'd4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .en_hit       (en_hit),
        .oct_up       (oct_up),
        .oct_down     (oct_down),
        .note_key     (note_key),
        .length_key   (length_key),
        .system_clock (system_clock),
        .hit_ready    (hit_ready),
        .hit_valid    (hit_valid),
        .hit_clock    (hit_clock),
        .hit_octave   (hit_octave),
        .hit_note     (hit_note),
        .hit_length   (hit_length),
        .octave       (octave),
        .hit_dropped  (hit_dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] c, input logic [1:0] o, input logic [2:0] nt, input logic [2:0] ln);
        rec_t r;
        r.clk_v = c; r.oct = o; r.note = nt; r.len = ln;
        exp_q.push_back(r);
    endtask

    task automatic press_oct(input logic up, input logic down, input logic [1:0] exp_oct, input string name);
        oct_up = up; oct_down = down;
        step(7);
        oct_up = 1'b0; oct_down = 1'b0;
        step(7);
        check(name, octave, exp_oct);
    endtask

    task automatic ready_pulse(input string name);
        hit_ready = 1'b1;
        step(1);
        hit_ready = 1'b0;
        check(name, hit_valid, 1'b0);
    endtask

    // Monitor: compare every newly presented record, and hold-stability under backpressure.
    always @(negedge clk) begin
        got = {hit_clock, hit_octave, hit_note, hit_length};
        if (hit_valid && (!prev_valid || prev_xfer)) begin
            n_records++;
            if (exp_q.size() == 0) begin
                check("record_expected", exp_q.size(), 1);
            end else begin
                last_exp = exp_q.pop_front();
                check("record_fields", got, last_exp);
            end
        end else if (hit_valid && prev_valid && !prev_xfer) begin
            check("record_stable", got, last_exp);
        end
        prev_valid = hit_valid;
        prev_xfer  = hit_valid && hit_ready;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; en_hit = 1'b0; oct_up = 1'b0; oct_down = 1'b0;
        note_key = 7'd0; length_key = 4'd0; system_clock = 32'd0; hit_ready = 1'b0;
        step(2);
        check("reset_octave", octave, 2'd1);
        check("reset_valid", hit_valid, 1'b0);
        check("reset_dropped", hit_dropped, 1'b0);
        check("reset_fields", {hit_clock, hit_octave, hit_note, hit_length}, 40'd0);
        rst_n = 1'b1; en = 1'b1;
        step(2);

        // Basic hit with exact latency.
        note_key = 7'b0000100; length_key = 4'b0010; system_clock = 32'd1000;
        step(8);
        push(32'd1000, 2'd1, 3'd3, 3'd2);
        en_hit = 1'b1;
        step(5);
        check("basic_latency_early", hit_valid, 1'b0);
        step(1);
        check("basic_latency", hit_valid, 1'b1);
        en_hit = 1'b0;
        step(8);
        ready_pulse("basic_transfer");

        // Bounce restarts the counter; multiple keys resolve to the lowest.
        note_key = 7'b1010000; length_key = 4'b1100; system_clock = 32'd2000;
        step(8);
        push(32'd2000, 2'd1, 3'd5, 3'd3);
        en_hit = 1'b1; step(1);
        en_hit = 1'b0; step(1);
        en_hit = 1'b1;
        step(5);
        check("bounce_latency_early", hit_valid, 1'b0);
        step(1);
        check("bounce_latency", hit_valid, 1'b1);
        step(8);
        en_hit = 1'b0;
        step(8);
        ready_pulse("bounce_transfer");

        // Octave saturation and cancellation.
        press_oct(1'b1, 1'b0, 2'd2, "oct_up_1");
        press_oct(1'b1, 1'b0, 2'd2, "oct_up_2");
        press_oct(1'b1, 1'b0, 2'd2, "oct_up_3");
        press_oct(1'b0, 1'b1, 2'd1, "oct_down_1");
        press_oct(1'b0, 1'b1, 2'd0, "oct_down_2");
        press_oct(1'b0, 1'b1, 2'd0, "oct_down_3");
        press_oct(1'b1, 1'b0, 2'd1, "oct_up_4");
        press_oct(1'b1, 1'b1, 2'd1, "oct_both");

        // Backpressure and drop.
        note_key = 7'b0000001; length_key = 4'b0001; system_clock = 32'd3000;
        step(8);
        push(32'd3000, 2'd1, 3'd1, 3'd1);
        en_hit = 1'b1; step(7);
        en_hit = 1'b0; step(7);
        check("bp_valid", hit_valid, 1'b1);
        check("bp_no_drop_yet", hit_dropped, 1'b0);
        note_key = 7'b0000010; system_clock = 32'd4000;
        step(8);
        en_hit = 1'b1; step(7);
        check("drop_flag", hit_dropped, 1'b1);
        check("drop_valid", hit_valid, 1'b1);
        en_hit = 1'b0; step(7);
        ready_pulse("drop_transfer");
        check("drop_sticky", hit_dropped, 1'b1);

        // Same-cycle accept and reload, with an octave step in the capture cycle.
        note_key = 7'b0000010; length_key = 4'b1000; system_clock = 32'd5000;
        step(8);
        push(32'd5000, 2'd1, 3'd2, 3'd4);
        en_hit = 1'b1; step(7);
        en_hit = 1'b0; step(7);
        note_key = 7'b0100000; system_clock = 32'd6000;
        step(8);
        push(32'd6000, 2'd1, 3'd6, 3'd4);
        en_hit = 1'b1; oct_up = 1'b1;
        step(5);
        hit_ready = 1'b1;
        step(1);
        hit_ready = 1'b0;
        check("reload_valid", hit_valid, 1'b1);
        check("reload_octave", octave, 2'd2);
        en_hit = 1'b0; oct_up = 1'b0;
        step(7);
        check("pre_disable_dropped", hit_dropped, 1'b1);

        // Disable mid-pending, then enable with the hit button already held.
        en = 1'b0;
        step(1);
        check("disable_valid", hit_valid, 1'b0);
        check("disable_dropped", hit_dropped, 1'b0);
        check("disable_octave", octave, 2'd1);
        en_hit = 1'b1;
        step(8);
        check("disabled_ignore", hit_valid, 1'b0);
        en = 1'b1;
        step(10);
        check("enable_no_record", hit_valid, 1'b0);
        en_hit = 1'b0;
        step(8);

        check("scoreboard_drained", exp_q.size(), 0);
        check("record_count", n_records, 5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
